membus_arbiter: RTL and testbench

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

---
 rtl/membus_pkg.sv | 16 +
 rtl/membus_arbiter_if.sv | 67 ++++++
 rtl/membus_timeout.sv | 30 +++
 rtl/membus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_membus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/membus_pkg.sv
// Shared types and defaults for the memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package membus_pkg;

  localparam int          MB_AW           = 20;
  localparam int unsigned MB_PROT_LIMIT   = 32'h0000_0400;
  localparam int          MB_ADDR_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ADDR = 2'd1,
    DMA_OP   = 2'd2
  } mb_state_t;

endpackage

// File: rtl/membus_arbiter_if.sv
// CPU, DMA and RAM-side signal bundle for the memory bus arbiter.
// Latency: n/a (wires only).
// Backpressure: DMA holds dma_req until dma_ack; the CPU side has no stall.
interface membus_arbiter_if
  import membus_pkg::*;
#(
  parameter int AW = MB_AW
) ();

  // CPU side
  logic [63:0]   cpu_ad;
  logic [7:0]    cpu_tag;
  logic          cpu_astb;
  logic          cpu_atomic;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          cpu_wforce;
  logic [63:0]   cpu_data;
  logic [7:0]    cpu_dtag;

  // DMA side
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [63:0]   dma_wdata;
  logic [7:0]    dma_wtag;
  logic          dma_ack;
  logic [63:0]   dma_rdata;
  logic [7:0]    dma_rtag;

  // RAM side (synchronous RAM, one-cycle read latency)
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_wtag;
  logic          mem_re;
  logic          mem_we;
  logic [63:0]   mem_rdata;
  logic [7:0]    mem_rtag;

  // Status
  logic          prot_err;
  logic          timeout_err;
  logic          locked;

  // Arbiter view
  modport slave (
    input  cpu_ad, cpu_tag, cpu_astb, cpu_atomic, cpu_rd, cpu_wr, cpu_wforce,
    output cpu_data, cpu_dtag,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_wtag,
    output dma_ack, dma_rdata, dma_rtag,
    output mem_addr, mem_wdata, mem_wtag, mem_re, mem_we,
    input  mem_rdata, mem_rtag,
    output prot_err, timeout_err, locked
  );

  // Environment view (CPU, DMA engine and RAM together)
  modport master (
    output cpu_ad, cpu_tag, cpu_astb, cpu_atomic, cpu_rd, cpu_wr, cpu_wforce,
    input  cpu_data, cpu_dtag,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_wtag,
    input  dma_ack, dma_rdata, dma_rtag,
    input  mem_addr, mem_wdata, mem_wtag, mem_re, mem_we,
    output mem_rdata, mem_rtag,
    input  prot_err, timeout_err, locked
  );

endinterface

// File: rtl/membus_timeout.sv
// Idle-cycle counter that flags an address phase left hanging too long.
// Latency: expire is combinational in the LIMIT-th consecutive enabled cycle.
// Backpressure: none; clear wins over enable.
module membus_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  assign expire = enable && (cnt_q == LAST);

  // Count enabled cycles; wrap to zero on expiry so the pulse is one cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= expire ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates one shared synchronous RAM between a CPU address/data bus and a DMA port.
// Latency: RAM op issued in the rd/wr/grant cycle; read data returned the following cycle.
// Backpressure: CPU always wins; DMA holds dma_req until its one-cycle dma_ack and may starve.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int          AW           = MB_AW,
  parameter int unsigned PROT_LIMIT   = MB_PROT_LIMIT,
  parameter int          ADDR_TIMEOUT = MB_ADDR_TIMEOUT
) (
  input logic             clk,
  input logic             reset,
  membus_arbiter_if.slave bus
);

  localparam logic [AW-1:0] PROT_LIM_A = AW'(PROT_LIMIT);

  mb_state_t     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          atomic_q, atomic_d;
  logic          locked_q, locked_d;
  logic          cpu_rd_q, dma_rd_q, rst_q;
  logic [63:0]   cpu_data_q, dma_rdata_q;
  logic [7:0]    cpu_dtag_q, dma_rtag_q;

  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_wtag;
  logic          prot_err, timeout_err, dma_ack;
  logic          dma_grant, cpu_rd_issue;
  logic          write_prot, tmo_en, tmo_expire;

  assign write_prot = (addr_q < PROT_LIM_A) && !bus.cpu_wforce;

  // Idle address-phase cycles are those in CPU_ADDR with no strobe, read or write.
  assign tmo_en = (state_q == CPU_ADDR) && !bus.cpu_astb && !bus.cpu_rd
                  && !bus.cpu_wr && !reset;

  membus_timeout #(
    .LIMIT(ADDR_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (!tmo_en),
    .enable(tmo_en),
    .expire(tmo_expire)
  );

  // Next state, RAM command and status pulses; everything is forced idle while reset is high.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    atomic_d     = atomic_q;
    locked_d     = locked_q;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = addr_q;
    mem_wdata    = bus.cpu_ad;
    mem_wtag     = bus.cpu_tag;
    prot_err     = 1'b0;
    timeout_err  = 1'b0;
    dma_ack      = 1'b0;
    dma_grant    = 1'b0;
    cpu_rd_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_astb) begin
          addr_d   = bus.cpu_ad[AW-1:0];
          atomic_d = bus.cpu_atomic;
          locked_d = 1'b0;
          state_d  = CPU_ADDR;
        end else if (bus.dma_req && !locked_q && !rst_q) begin
          // rst_q keeps the RAM quiet in the first cycle out of reset.
          dma_grant = 1'b1;
          mem_addr  = bus.dma_addr;
          mem_wdata = bus.dma_wdata;
          mem_wtag  = bus.dma_wtag;
          mem_we    = bus.dma_we;
          mem_re    = !bus.dma_we;
          state_d   = DMA_OP;
        end
      end

      CPU_ADDR: begin
        if (bus.cpu_astb) begin
          // A fresh strobe restarts the access and drops any lock.
          addr_d   = bus.cpu_ad[AW-1:0];
          atomic_d = bus.cpu_atomic;
          locked_d = 1'b0;
        end else if (bus.cpu_rd) begin
          // Read wins over a simultaneous write.
          mem_re       = 1'b1;
          cpu_rd_issue = 1'b1;
          if (atomic_q) begin
            locked_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.cpu_wr) begin
          // A protected write is dropped but still ends the access.
          mem_we   = !write_prot;
          prot_err = write_prot;
          locked_d = 1'b0;
          state_d  = IDLE;
        end else if (tmo_expire) begin
          timeout_err = 1'b1;
          locked_d    = 1'b0;
          state_d     = IDLE;
        end
      end

      DMA_OP: begin
        dma_ack = 1'b1;
        if (bus.cpu_astb) begin
          addr_d   = bus.cpu_ad[AW-1:0];
          atomic_d = bus.cpu_atomic;
          locked_d = 1'b0;
          state_d  = CPU_ADDR;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (reset) begin
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      prot_err     = 1'b0;
      timeout_err  = 1'b0;
      dma_ack      = 1'b0;
      dma_grant    = 1'b0;
      cpu_rd_issue = 1'b0;
    end
  end

  // Control state: FSM, latched address, lock and read-return flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      atomic_q <= 1'b0;
      locked_q <= 1'b0;
      cpu_rd_q <= 1'b0;
      dma_rd_q <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      atomic_q <= atomic_d;
      locked_q <= locked_d;
      cpu_rd_q <= cpu_rd_issue;
      dma_rd_q <= dma_grant && !bus.dma_we;
      rst_q    <= 1'b0;
    end
  end

  // Hold the last returned read data so it stays stable between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_data_q  <= '0;
      cpu_dtag_q  <= '0;
      dma_rdata_q <= '0;
      dma_rtag_q  <= '0;
    end else begin
      if (cpu_rd_q) begin
        cpu_data_q <= bus.mem_rdata;
        cpu_dtag_q <= bus.mem_rtag;
      end
      if (dma_rd_q) begin
        dma_rdata_q <= bus.mem_rdata;
        dma_rtag_q  <= bus.mem_rtag;
      end
    end
  end

  // RAM output is forwarded in its return cycle, then the held copy takes over.
  assign bus.cpu_data    = cpu_rd_q ? bus.mem_rdata : cpu_data_q;
  assign bus.cpu_dtag    = cpu_rd_q ? bus.mem_rtag  : cpu_dtag_q;
  assign bus.dma_rdata   = dma_rd_q ? bus.mem_rdata : dma_rdata_q;
  assign bus.dma_rtag    = dma_rd_q ? bus.mem_rtag  : dma_rtag_q;
  assign bus.dma_ack     = dma_ack;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_wtag    = mem_wtag;
  assign bus.mem_re      = mem_re;
  assign bus.mem_we      = mem_we;
  assign bus.prot_err    = prot_err;
  assign bus.timeout_err = timeout_err;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter with a behavioural synchronous RAM.
// Latency: checks same-cycle RAM commands and next-cycle read returns.
// Backpressure: DMA requests are held until dma_ack.
module tb_membus_arbiter;
  import membus_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;
  int prot_cnt = 0;
  int tmo_cnt  = 0;
  int ack_cnt  = 0;

  logic [63:0] ram_d [int];
  logic [7:0]  ram_t [int];
  logic [63:0] ram_q = '0;
  logic [7:0]  ram_tq = '0;
  int          ram_a;

  membus_arbiter_if #(.AW(20)) bus ();

  membus_arbiter #(
    .AW          (20),
    .PROT_LIMIT  (32'h400),
    .ADDR_TIMEOUT(255)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = ram_q;
  assign bus.mem_rtag  = ram_tq;

  // Synchronous RAM model with one-cycle read latency
  always @(posedge clk) begin
    ram_a = int'(bus.mem_addr);
    if (bus.mem_we) begin
      ram_d[ram_a] = bus.mem_wdata;
      ram_t[ram_a] = bus.mem_wtag;
    end
    if (bus.mem_re) begin
      if (ram_d.exists(ram_a)) begin
        ram_q  <= ram_d[ram_a];
        ram_tq <= ram_t[ram_a];
      end else begin
        ram_q  <= '0;
        ram_tq <= '0;
      end
    end
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.prot_err)    prot_cnt++;
    if (bus.timeout_err) tmo_cnt++;
    if (bus.dma_ack)     ack_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.cpu_ad     = '0;
    bus.cpu_tag    = '0;
    bus.cpu_astb   = 1'b0;
    bus.cpu_atomic = 1'b0;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_wforce = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0, t0, a0, hit;

    ram_d[32'h01234] = 64'hDEADBEEF_00000001; ram_t[32'h01234] = 8'h35;
    ram_d[32'h02000] = 64'h01234567_89ABCDEF; ram_t[32'h02000] = 8'h77;
    ram_d[32'h03000] = 64'hCAFEF00D_12345678; ram_t[32'h03000] = 8'h5A;
    ram_d[32'h03008] = 64'h00001111_22223333; ram_t[32'h03008] = 8'h11;

    clr_in();
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
    bus.dma_wtag  = '0;
    reset = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_locked", bus.locked, 1'b0);
    chk("rst_mem_re", bus.mem_re, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_dma_ack", bus.dma_ack, 1'b0);
    chk("rst_cpu_data", bus.cpu_data, 64'h0);
    chk("rst_dma_rdata", bus.dma_rdata, 64'h0);
    chk("rst_prot_err", bus.prot_err, 1'b0);
    chk("rst_timeout_err", bus.timeout_err, 1'b0);
    reset = 1'b0;

    // Plain CPU read
    bus.cpu_astb = 1'b1; bus.cpu_ad = 64'h01234;
    #1 chk("rd_astb_no_op", bus.mem_re | bus.mem_we, 1'b0);
    tick();
    clr_in(); bus.cpu_rd = 1'b1;
    #1 chk("rd_mem_re", bus.mem_re, 1'b1);
    chk("rd_mem_addr", bus.mem_addr, 20'h01234);
    tick();
    clr_in();
    #1 chk("rd_cpu_data", bus.cpu_data, 64'hDEADBEEF_00000001);
    chk("rd_cpu_dtag", bus.cpu_dtag, 8'h35);
    chk("rd_state_idle", dut.state_q, IDLE);
    tick();
    chk("rd_data_held", bus.cpu_data, 64'hDEADBEEF_00000001);

    // Protected write, then forced write
    p0 = prot_cnt;
    bus.cpu_astb = 1'b1; bus.cpu_ad = 64'h00010;
    tick();
    clr_in(); bus.cpu_wr = 1'b1; bus.cpu_ad = 64'h1111; bus.cpu_tag = 8'h01;
    #1 chk("prot_mem_we", bus.mem_we, 1'b0);
    chk("prot_err_pulse", bus.prot_err, 1'b1);
    tick();
    clr_in();
    #1 chk("prot_state_idle", dut.state_q, IDLE);
    chk("prot_err_cleared", bus.prot_err, 1'b0);
    bus.cpu_astb = 1'b1; bus.cpu_ad = 64'h00010;
    tick();
    clr_in(); bus.cpu_wr = 1'b1; bus.cpu_wforce = 1'b1;
    bus.cpu_ad = 64'h5555AAAA_12345678; bus.cpu_tag = 8'hC3;
    #1 chk("force_mem_we", bus.mem_we, 1'b1);
    chk("force_no_prot", bus.prot_err, 1'b0);
    chk("force_wdata", bus.mem_wdata, 64'h5555AAAA_12345678);
    chk("force_wtag", bus.mem_wtag, 8'hC3);
    tick();
    clr_in();
    #1 chk("force_ram", ram_d[32'h10], 64'h5555AAAA_12345678);
    chk("prot_pulse_count", 64'(prot_cnt - p0), 64'd1);

    // Atomic read-modify-write blocks DMA
    a0 = ack_cnt;
    bus.cpu_astb = 1'b1; bus.cpu_atomic = 1'b1; bus.cpu_ad = 64'h02000;
    tick();
    clr_in(); bus.cpu_rd = 1'b1;
    #1 chk("atom_mem_re", bus.mem_re, 1'b1);
    tick();
    clr_in();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 20'h03008;
    #1 chk("atom_rdata", bus.cpu_data, 64'h01234567_89ABCDEF);
    for (int i = 0; i < 3; i++) begin
      chk("atom_locked", bus.locked, 1'b1);
      chk("atom_no_grant", bus.mem_re | bus.mem_we | bus.dma_ack, 1'b0);
      tick();
    end
    bus.cpu_wr = 1'b1; bus.cpu_ad = 64'hA5A5A5A5_5A5A5A5A; bus.cpu_tag = 8'h99;
    #1 chk("atom_wr", bus.mem_we, 1'b1);
    chk("atom_wr_addr", bus.mem_addr, 20'h02000);
    tick();
    clr_in();
    #1 chk("atom_unlocked", bus.locked, 1'b0);
    chk("atom_dma_grant", bus.mem_re, 1'b1);
    chk("atom_dma_addr", bus.mem_addr, 20'h03008);
    tick();
    chk("atom_dma_ack", bus.dma_ack, 1'b1);
    chk("atom_dma_rdata", bus.dma_rdata, 64'h00001111_22223333);
    chk("atom_dma_rtag", bus.dma_rtag, 8'h11);
    bus.dma_req = 1'b0;
    tick();
    chk("atom_ack_once", 64'(ack_cnt - a0), 64'd1);
    chk("atom_state_idle", dut.state_q, IDLE);

    // CPU beats DMA in the same cycle
    bus.cpu_astb = 1'b1; bus.cpu_ad = 64'h01234;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 20'h03000;
    #1 chk("cpuwin_no_op", bus.mem_re | bus.mem_we, 1'b0);
    tick();
    clr_in(); bus.cpu_rd = 1'b1;
    #1 chk("cpuwin_addr", bus.mem_addr, 20'h01234);
    tick();
    clr_in();
    #1 chk("cpuwin_dma_re", bus.mem_re, 1'b1);
    chk("cpuwin_dma_addr", bus.mem_addr, 20'h03000);
    tick();
    chk("cpuwin_ack", bus.dma_ack, 1'b1);
    chk("cpuwin_rdata", bus.dma_rdata, 64'hCAFEF00D_12345678);
    chk("cpuwin_rtag", bus.dma_rtag, 8'h5A);
    bus.dma_req = 1'b0;
    tick();

    // Read takes precedence over write
    bus.cpu_astb = 1'b1; bus.cpu_ad = 64'h01234;
    tick();
    clr_in(); bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_wforce = 1'b1;
    #1 chk("rdwr_re", bus.mem_re, 1'b1);
    chk("rdwr_no_we", bus.mem_we, 1'b0);
    tick();
    clr_in();

    // Address-phase timeout, then pending DMA write below the protect limit
    t0 = tmo_cnt;
    hit = 0;
    bus.cpu_astb = 1'b1; bus.cpu_ad = 64'h01234;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 20'h00020;
    bus.dma_wdata = 64'h0000ABCD_0000EF01; bus.dma_wtag = 8'h42;
    tick();
    clr_in();
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (bus.timeout_err) begin
        hit = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("tmo_cycle", 64'(hit), 64'd255);
    tick();
    chk("tmo_state_idle", dut.state_q, IDLE);
    chk("tmo_locked", bus.locked, 1'b0);
    chk("tmo_dma_we", bus.mem_we, 1'b1);
    chk("tmo_dma_addr", bus.mem_addr, 20'h00020);
    tick();
    chk("tmo_dma_ack", bus.dma_ack, 1'b1);
    bus.dma_req = 1'b0;
    tick();
    chk("tmo_ram", ram_d[32'h20], 64'h0000ABCD_0000EF01);
    chk("tmo_pulse_count", 64'(tmo_cnt - t0), 64'd1);

    // Reset during a locked atomic access
    a0 = ack_cnt;
    bus.cpu_astb = 1'b1; bus.cpu_atomic = 1'b1; bus.cpu_ad = 64'h02000;
    tick();
    clr_in(); bus.cpu_rd = 1'b1;
    tick();
    clr_in();
    #1 chk("rstlk_locked", bus.locked, 1'b1);
    reset = 1'b1;
    bus.cpu_wr = 1'b1; bus.cpu_ad = 64'h77;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 20'h03000;
    #1 chk("rstlk_no_we", bus.mem_we, 1'b0);
    chk("rstlk_no_ack", bus.dma_ack, 1'b0);
    tick();
    reset = 1'b0;
    clr_in();
    #1 chk("rstlk_unlocked", bus.locked, 1'b0);
    chk("rstlk_state", dut.state_q, IDLE);
    chk("rstlk_quiet", bus.mem_re | bus.mem_we | bus.dma_ack, 1'b0);
    tick();
    chk("rstlk_late_grant", bus.mem_re, 1'b1);
    tick();
    bus.dma_req = 1'b0;
    tick();
    chk("rstlk_ack_count", 64'(ack_cnt - a0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
